// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: instruction field positions, control width
// default, register-zero constant and immediate extension helper.
package pipe_pkg;

    localparam int unsigned RS_HI  = 25;
    localparam int unsigned RS_LO  = 21;
    localparam int unsigned RT_HI  = 20;
    localparam int unsigned RT_LO  = 16;
    localparam int unsigned IMM_HI = 15;
    localparam int unsigned IMM_LO = 0;

    localparam int unsigned CTRL_W_DEFAULT = 12;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    // Sign- or zero-extend a 16-bit immediate to 32 bits.
    function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic sext);
        return {{16{imm[15] & sext}}, imm};
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX register bundle presented to the EX stage.
interface id_ex_stage_if #(
    parameter int unsigned CTRL_W = pipe_pkg::CTRL_W_DEFAULT
);
    logic              ex_valid;
    logic [31:0]       ex_pc;
    logic [31:0]       ex_rs_data;
    logic [31:0]       ex_rt_data;
    logic [31:0]       ex_imm;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_rd;
    logic              ex_mem_read;
    logic [CTRL_W-1:0] ex_ctrl;

    modport master (
        output ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_mem_read, ex_ctrl
    );

    modport slave (
        input  ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_mem_read, ex_ctrl
    );
endinterface

// File: rtl/id_ex_stage_hazard.sv
// Load-use hazard detection and stall generation (purely combinational).
module hazard_unit
    import pipe_pkg::*;
(
    input  logic     ex_valid_i,
    input  logic     ex_mem_read_i,
    input  reg_idx_t ex_rd_i,
    input  logic     if_id_valid_i,
    input  logic     id_uses_rs_i,
    input  logic     id_uses_rt_i,
    input  reg_idx_t id_rs_i,
    input  reg_idx_t id_rt_i,
    input  logic     ex_hold_i,
    input  logic     flush_i,
    output logic     hz_o,
    output logic     stall_o
);

    // A load in EX whose destination feeds the ID instruction forces one bubble.
    always_comb begin
        hz_o    = ex_valid_i && ex_mem_read_i && (ex_rd_i != REG_ZERO) && if_id_valid_i &&
                  ((id_uses_rs_i && (ex_rd_i == id_rs_i)) ||
                   (id_uses_rt_i && (ex_rd_i == id_rt_i)));
        stall_o = (hz_o || ex_hold_i) && !flush_i;
    end

endmodule

// File: rtl/id_ex_stage.sv
// Operand collection with write-back bypass, load-use bubbling and the
// ID/EX pipeline register.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = CTRL_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_id_valid,
    input  logic [31:0]       if_id_pc,
    input  logic [31:0]       if_id_instr,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_mem_read,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [4:0]        id_rd,
    input  logic              id_sign_ext,
    output logic [4:0]        rf_ra1,
    output logic [4:0]        rf_ra2,
    input  logic [31:0]       rf_rd1,
    input  logic [31:0]       rf_rd2,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_data,
    input  logic              ex_hold,
    input  logic              flush,
    output logic              stall,
    id_ex_stage_if.master     ex
);

    reg_idx_t    rs;
    reg_idx_t    rt;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hz;

    logic              valid_q,    valid_d;
    logic [31:0]       pc_q,       pc_d;
    logic [31:0]       rs_data_q,  rs_data_d;
    logic [31:0]       rt_data_q,  rt_data_d;
    logic [31:0]       imm_q,      imm_d;
    reg_idx_t          rs_q,       rs_d;
    reg_idx_t          rt_q,       rt_d;
    reg_idx_t          rd_q,       rd_d;
    logic              mem_read_q, mem_read_d;
    logic [CTRL_W-1:0] ctrl_q,     ctrl_d;

    assign rs     = if_id_instr[RS_HI:RS_LO];
    assign rt     = if_id_instr[RT_HI:RT_LO];
    assign rf_ra1 = rs;
    assign rf_ra2 = rt;

    hazard_unit u_hazard (
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (mem_read_q),
        .ex_rd_i       (rd_q),
        .if_id_valid_i (if_id_valid),
        .id_uses_rs_i  (id_uses_rs),
        .id_uses_rt_i  (id_uses_rt),
        .id_rs_i       (rs),
        .id_rt_i       (rt),
        .ex_hold_i     (ex_hold),
        .flush_i       (flush),
        .hz_o          (hz),
        .stall_o       (stall)
    );

    // Bypass the write-back result over stale register-file data (never r0).
    always_comb begin
        rs_val = (wb_we && (wb_rd != REG_ZERO) && (wb_rd == rs)) ? wb_data : rf_rd1;
        rt_val = (wb_we && (wb_rd != REG_ZERO) && (wb_rd == rt)) ? wb_data : rt_val_rf();
    end

    function automatic logic [31:0] rt_val_rf();
        return rf_rd2;
    endfunction

    // Next-state priority: flush, hold (with WB refresh), bubble, capture.
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs_data_d  = rs_data_q;
        rt_data_d  = rt_data_q;
        imm_d      = imm_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        mem_read_d = mem_read_q;
        ctrl_d     = ctrl_q;
        if (flush) begin
            valid_d    = 1'b0;
            pc_d       = '0;
            rs_data_d  = '0;
            rt_data_d  = '0;
            imm_d      = '0;
            rs_d       = '0;
            rt_d       = '0;
            rd_d       = '0;
            mem_read_d = 1'b0;
            ctrl_d     = '0;
        end else if (ex_hold) begin
            // A held instruction must still see results retiring under it.
            if (wb_we && (wb_rd != REG_ZERO) && (wb_rd == rs_q)) rs_data_d = wb_data;
            if (wb_we && (wb_rd != REG_ZERO) && (wb_rd == rt_q)) rt_data_d = wb_data;
        end else if (hz) begin
            valid_d    = 1'b0;
            mem_read_d = 1'b0;
            ctrl_d     = '0;
        end else begin
            valid_d    = if_id_valid;
            pc_d       = if_id_pc;
            rs_data_d  = rs_val;
            rt_data_d  = rt_val;
            imm_d      = ext_imm(if_id_instr[IMM_HI:IMM_LO], id_sign_ext);
            rs_d       = rs;
            rt_d       = rt;
            rd_d       = id_rd;
            mem_read_d = id_mem_read & if_id_valid;
            ctrl_d     = if_id_valid ? id_ctrl : '0;
        end
    end

    // ID/EX register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            mem_read_q <= 1'b0;
            ctrl_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs_data_q  <= rs_data_d;
            rt_data_q  <= rt_data_d;
            imm_q      <= imm_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            mem_read_q <= mem_read_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign ex.ex_valid    = valid_q;
    assign ex.ex_pc       = pc_q;
    assign ex.ex_rs_data  = rs_data_q;
    assign ex.ex_rt_data  = rt_data_q;
    assign ex.ex_imm      = imm_q;
    assign ex.ex_rs       = rs_q;
    assign ex.ex_rt       = rt_q;
    assign ex.ex_rd       = rd_q;
    assign ex.ex_mem_read = mem_read_q;
    assign ex.ex_ctrl     = ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomised checks of id_ex_stage against a behavioural model.
module tb_id_ex_stage;

    localparam int unsigned CW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_id_valid;
    logic [31:0]   if_id_pc;
    logic [31:0]   if_id_instr;
    logic [CW-1:0] id_ctrl;
    logic          id_mem_read;
    logic          id_uses_rs;
    logic          id_uses_rt;
    logic [4:0]    id_rd;
    logic          id_sign_ext;
    logic [4:0]    rf_ra1;
    logic [4:0]    rf_ra2;
    logic [31:0]   rf_rd1;
    logic [31:0]   rf_rd2;
    logic          wb_we;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic          ex_hold;
    logic          flush;
    logic          stall;

    id_ex_stage_if #(.CTRL_W(CW)) ex_if ();

    id_ex_stage #(.CTRL_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .id_ctrl     (id_ctrl),
        .id_mem_read (id_mem_read),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .id_rd       (id_rd),
        .id_sign_ext (id_sign_ext),
        .rf_ra1      (rf_ra1),
        .rf_ra2      (rf_ra2),
        .rf_rd1      (rf_rd1),
        .rf_rd2      (rf_rd2),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .ex_hold     (ex_hold),
        .flush       (flush),
        .stall       (stall),
        .ex          (ex_if)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of what EX must hold.
    logic          m_ready = 1'b0;
    logic          m_known;
    logic          m_valid;
    logic [31:0]   m_pc, m_rsd, m_rtd, m_imm;
    logic [4:0]    m_rs, m_rt, m_rd;
    logic          m_mem;
    logic [CW-1:0] m_ctrl;

    function automatic logic [31:0] bypassed(input logic [4:0] r, input logic [31:0] rf);
        if (wb_we && wb_rd != 5'd0 && wb_rd == r) return wb_data;
        return rf;
    endfunction

    function automatic logic model_hz();
        logic [4:0] s;
        logic [4:0] t;
        s = if_id_instr[25:21];
        t = if_id_instr[20:16];
        return m_valid && m_mem && m_rd != 5'd0 && if_id_valid &&
               ((id_uses_rs && m_rd == s) || (id_uses_rt && m_rd == t));
    endfunction

    always @(posedge clk) begin
        m_ready <= 1'b1;
        if (rst || flush) begin
            m_valid <= 1'b0; m_pc <= 32'd0; m_rsd <= 32'd0; m_rtd <= 32'd0; m_imm <= 32'd0;
            m_rs <= 5'd0; m_rt <= 5'd0; m_rd <= 5'd0; m_mem <= 1'b0; m_ctrl <= '0;
            m_known <= 1'b1;
        end else if (ex_hold) begin
            m_rsd <= bypassed(m_rs, m_rsd);
            m_rtd <= bypassed(m_rt, m_rtd);
        end else if (model_hz()) begin
            m_valid <= 1'b0; m_mem <= 1'b0; m_ctrl <= '0; m_known <= 1'b0;
        end else begin
            m_valid <= if_id_valid;
            m_pc    <= if_id_pc;
            m_rsd   <= bypassed(if_id_instr[25:21], rf_rd1);
            m_rtd   <= bypassed(if_id_instr[20:16], rf_rd2);
            m_imm   <= id_sign_ext ? 32'($signed(if_id_instr[15:0])) : {16'h0000, if_id_instr[15:0]};
            m_rs    <= if_id_instr[25:21];
            m_rt    <= if_id_instr[20:16];
            m_rd    <= id_rd;
            m_mem   <= if_id_valid && id_mem_read;
            m_ctrl  <= if_id_valid ? id_ctrl : '0;
            m_known <= 1'b1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_ready) begin
            chk("ra1", {27'd0, rf_ra1}, {27'd0, if_id_instr[25:21]});
            chk("ra2", {27'd0, rf_ra2}, {27'd0, if_id_instr[20:16]});
            chk("stall", {31'd0, stall}, {31'd0, (model_hz() || ex_hold) && !flush});
            chk("valid", {31'd0, ex_if.ex_valid}, {31'd0, m_valid});
            chk("mem_read", {31'd0, ex_if.ex_mem_read}, {31'd0, m_mem});
            chk("ctrl", {20'd0, ex_if.ex_ctrl}, {20'd0, m_ctrl});
            if (m_known) begin
                chk("pc", ex_if.ex_pc, m_pc);
                chk("rs_data", ex_if.ex_rs_data, m_rsd);
                chk("rt_data", ex_if.ex_rt_data, m_rtd);
                chk("imm", ex_if.ex_imm, m_imm);
                chk("rs", {27'd0, ex_if.ex_rs}, {27'd0, m_rs});
                chk("rt", {27'd0, ex_if.ex_rt}, {27'd0, m_rt});
                chk("rd", {27'd0, ex_if.ex_rd}, {27'd0, m_rd});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                             input logic [CW-1:0] ctl, input logic mr, input logic urs,
                             input logic urt, input logic [4:0] rd, input logic sx);
        if_id_valid = v;   if_id_pc = pc;   if_id_instr = ins; id_ctrl = ctl;
        id_mem_read = mr;  id_uses_rs = urs; id_uses_rt = urt; id_rd = rd;
        id_sign_ext = sx;
    endtask

    task automatic rand_inputs(input logic allow_hold);
        logic [31:0] ins;
        ins = {6'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
        set_instr(1'($urandom), $urandom, ins, CW'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom));
        rf_rd1  = $urandom;
        rf_rd2  = $urandom;
        wb_we   = 1'($urandom);
        wb_rd   = 5'($urandom_range(0, 7));
        wb_data = $urandom;
        ex_hold = allow_hold && ($urandom_range(0, 3) == 0);
        flush   = ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        // Reset with random stimulus.
        rst = 1'b1;
        rand_inputs(1'b0);
        step();
        rand_inputs(1'b0);
        step();
        chk("rst_valid", {31'd0, ex_if.ex_valid}, 32'd0);
        chk("rst_pc", ex_if.ex_pc, 32'd0);
        chk("rst_rs_data", ex_if.ex_rs_data, 32'd0);
        chk("rst_imm", ex_if.ex_imm, 32'd0);
        chk("rst_ctrl", {20'd0, ex_if.ex_ctrl}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);

        rst = 1'b0; flush = 1'b0; ex_hold = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;

        // Plain capture: lw r2, -4(r1).
        set_instr(1'b1, 32'h1000, 32'h8C22FFFC, 12'hA51, 1'b1, 1'b1, 1'b0, 5'd2, 1'b1);
        rf_rd1 = 32'h100; rf_rd2 = 32'h222;
        step();
        chk("cap_imm", ex_if.ex_imm, 32'hFFFFFFFC);
        chk("cap_rs_data", ex_if.ex_rs_data, 32'h100);
        chk("cap_mem_read", {31'd0, ex_if.ex_mem_read}, 32'd1);
        chk("cap_rs", {27'd0, ex_if.ex_rs}, 32'd1);
        chk("cap_ctrl", {20'd0, ex_if.ex_ctrl}, 32'hA51);

        // WB bypass on rs=3, then wb_rd=0, then rs=0 with wb_rd=0.
        set_instr(1'b1, 32'h1004, 32'h00643020, 12'h011, 1'b0, 1'b1, 1'b1, 5'd6, 1'b1);
        rf_rd1 = 32'h1; rf_rd2 = 32'h4;
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD;
        step();
        chk("byp_rs_data", ex_if.ex_rs_data, 32'hDEAD);
        chk("byp_rt_data", ex_if.ex_rt_data, 32'h4);
        wb_rd = 5'd0;
        step();
        chk("byp_r0_rs_data", ex_if.ex_rs_data, 32'h1);
        set_instr(1'b1, 32'h1008, 32'h00043020, 12'h011, 1'b0, 1'b1, 1'b1, 5'd6, 1'b1);
        step();
        chk("byp_rs0_rs_data", ex_if.ex_rs_data, 32'h1);

        // Zero-extension of an immediate with bit 15 set: ori r5, r4, 0x8001.
        wb_we = 1'b0;
        set_instr(1'b1, 32'h100C, 32'h34858001, 12'h022, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0);
        step();
        chk("zext_imm", ex_if.ex_imm, 32'h00008001);

        // Load-use: lw r5 then add r7, r6, r5.
        set_instr(1'b1, 32'h1010, 32'h8C250008, 12'h0F1, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1);
        step();
        set_instr(1'b1, 32'h1014, 32'h00C53820, 12'h033, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1);
        rf_rd1 = 32'h66; rf_rd2 = 32'h77;
        #1;
        chk("lu_stall", {31'd0, stall}, 32'd1);
        step();
        chk("lu_bubble_valid", {31'd0, ex_if.ex_valid}, 32'd0);
        chk("lu_bubble_ctrl", {20'd0, ex_if.ex_ctrl}, 32'd0);
        chk("lu_stall_drop", {31'd0, stall}, 32'd0);
        step();
        chk("lu_dep_valid", {31'd0, ex_if.ex_valid}, 32'd1);
        chk("lu_dep_pc", ex_if.ex_pc, 32'h1014);
        chk("lu_dep_rt", {27'd0, ex_if.ex_rt}, 32'd5);

        // Hold for 3 cycles; WB writes r5 (= ex_rt) with 0x55 in cycle 2.
        set_instr(1'b1, 32'h1018, 32'h00E84820, 12'h044, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1);
        ex_hold = 1'b1;
        #1;
        chk("hold_stall_c1", {31'd0, stall}, 32'd1);
        step();
        chk("hold_rt_data_c1", ex_if.ex_rt_data, 32'h77);
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h55;
        #1;
        chk("hold_stall_c2", {31'd0, stall}, 32'd1);
        step();
        chk("hold_rt_data_c2", ex_if.ex_rt_data, 32'h55);
        chk("hold_pc_c2", ex_if.ex_pc, 32'h1014);
        wb_we = 1'b0;
        #1;
        chk("hold_stall_c3", {31'd0, stall}, 32'd1);
        step();
        chk("hold_rt_data_c3", ex_if.ex_rt_data, 32'h55);
        chk("hold_rs_data_c3", ex_if.ex_rs_data, 32'h66);
        chk("hold_ctrl_c3", {20'd0, ex_if.ex_ctrl}, 32'h033);
        ex_hold = 1'b0;
        step();
        chk("hold_release_pc", ex_if.ex_pc, 32'h1018);

        // Invalid dependent instruction never stalls but passes as a bubble.
        set_instr(1'b1, 32'h101C, 32'h8C250008, 12'h0F1, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1);
        step();
        set_instr(1'b0, 32'h1020, 32'h00C53820, 12'h033, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1);
        #1;
        chk("inv_stall", {31'd0, stall}, 32'd0);
        step();
        chk("inv_valid", {31'd0, ex_if.ex_valid}, 32'd0);
        chk("inv_ctrl", {20'd0, ex_if.ex_ctrl}, 32'd0);

        // Flush beats hazard and hold.
        set_instr(1'b1, 32'h1024, 32'h8C250008, 12'h0F1, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1);
        step();
        set_instr(1'b1, 32'h1028, 32'h00C53820, 12'h033, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1);
        ex_hold = 1'b1; flush = 1'b1;
        #1;
        chk("flush_stall", {31'd0, stall}, 32'd0);
        step();
        chk("flush_valid", {31'd0, ex_if.ex_valid}, 32'd0);
        chk("flush_ctrl", {20'd0, ex_if.ex_ctrl}, 32'd0);
        flush = 1'b0; ex_hold = 1'b0;

        // Reset during a load-use stall.
        set_instr(1'b1, 32'h102C, 32'h8C250008, 12'h0F1, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1);
        step();
        set_instr(1'b1, 32'h1030, 32'h00C53820, 12'h033, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1);
        #1;
        chk("rststall_pre", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        step();
        chk("rststall_valid", {31'd0, ex_if.ex_valid}, 32'd0);
        chk("rststall_pc", ex_if.ex_pc, 32'd0);
        chk("rststall_stall", {31'd0, stall}, 32'd0);
        rst = 1'b0;

        // Randomised traffic checked by the model each cycle.
        for (int i = 0; i < 400; i++) begin
            rand_inputs(1'b1);
            rst = ($urandom_range(0, 39) == 0);
            step();
        end
        rst = 1'b0; flush = 1'b0; ex_hold = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Operand-collection stage and ID/EX pipeline register for the pipelined core. Sits between IF/ID and EX, directly downstream of the register file.
- Drives the register-file read addresses from the IF/ID instruction.
- Bypasses the write-back result into the read data.
- Detects load-use hazards and inserts bubbles.
- Honours downstream hold and branch flush, then registers operands, immediate and control for EX.

## Interface
Parameters:
- CTRL_W, 12, width of the opaque EX/MEM/WB control bundle from the control unit.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- if_id_valid  in  1  IF/ID holds a real instruction.
- if_id_pc  in  32  PC of that instruction.
- if_id_instr  in  32  instruction word.
- id_ctrl  in  CTRL_W  decoded control bundle.
- id_mem_read  in  1  instruction is a load.
- id_uses_rs, id_uses_rt  in  1 each  instruction reads rs or rt.
- id_rd  in  5  destination register chosen by control (0 = none).
- id_sign_ext  in  1  sign-extend (1) or zero-extend (0) the immediate.
- rf_ra1, rf_ra2  out  5 each  register-file read addresses: instr[25:21] and instr[20:16].
- rf_rd1, rf_rd2  in  32 each  register-file read data.
- wb_we, wb_rd, wb_data  in  1/5/32  write-back port, same values driven to the register file.
- ex_hold  in  1  EX cannot accept; freeze this stage.
- flush  in  1  branch/jump resolved taken; kill the instruction entering EX.
- stall  out  1  hold PC and IF/ID this cycle.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc  out  32  PC of the EX instruction.
- ex_rs_data, ex_rt_data  out  32 each  operand values.
- ex_imm  out  32  extended immediate.
- ex_rs, ex_rt, ex_rd  out  5 each  register specifiers, used by the EX forwarding unit.
- ex_mem_read  out  1  EX instruction is a load.
- ex_ctrl  out  CTRL_W  control bundle.

## Operation
- rf_ra1 and rf_ra2 are purely combinational from if_id_instr.
- ID bypass (combinational):
  - rs_val = wb_data if wb_we && wb_rd != 0 && wb_rd == rs, else rf_rd1.
  - rt_val is formed the same way from rt and rf_rd2.
  - Register 0 is never bypassed.
- Load-use hazard:
  - hz = ex_valid && ex_mem_read && ex_rd != 0 && if_id_valid && ((id_uses_rs && ex_rd == rs) || (id_uses_rt && ex_rd == rt)).
- stall = (hz || ex_hold) && !flush, combinational.
- Register update at each rising edge, first match wins:
  1. rst: every ex_* output = 0.
  2. flush: ex_valid = 0, ex_mem_read = 0, ex_ctrl = 0, all other ex_* = 0. The IF/ID instruction is discarded.
  3. ex_hold: all ex_* registers keep their values, except refresh. Refresh: if wb_we && wb_rd != 0 && wb_rd == ex_rs, load wb_data into ex_rs_data; likewise for ex_rt and ex_rt_data.
  4. hz: insert a bubble. ex_valid = 0, ex_mem_read = 0, ex_ctrl = 0; other ex_* may take any value. IF/ID is held by stall.
  5. Otherwise, capture:
     - ex_valid = if_id_valid.
     - ex_pc = if_id_pc.
     - ex_rs_data = rs_val, ex_rt_data = rt_val.
     - ex_imm = {16{instr[15] & id_sign_ext}, instr[15:0]}.
     - ex_rs = instr[25:21], ex_rt = instr[20:16], ex_rd = id_rd.
     - ex_mem_read = id_mem_read & if_id_valid.
     - ex_ctrl = if_id_valid ? id_ctrl : 0.
- A bubble always has ex_ctrl = 0, so no write or memory side effects occur downstream.

## Timing
- Latency: 1 cycle from IF/ID to EX outputs.
- Load-use: exactly one bubble. Next cycle ex_mem_read = 0, so hz drops and the held instruction advances.
- Simultaneous flush and hold: flush wins and stall = 0.
- Simultaneous hz and hold: hold wins, the registers freeze, and stall = 1.
- rst asserted mid-stall clears everything on that edge. stall is 0 during reset because ex_valid is 0.
- An instruction that is not valid never raises hz; it still passes as a bubble.

## Structure
- Shared package pipe_pkg holds:
  - instruction field positions (RS_HI/LO, RT_HI/LO, IMM_HI/LO);
  - CTRL_W default;
  - REG_ZERO = 5'd0.
- One sub-module, hazard_unit: purely combinational hz/stall logic, reused later by the branch-in-ID logic.
- Forward muxes and ID/EX registers stay in id_ex_stage.

## Test plan
- Reset: assert rst for 2 cycles with random inputs -> all ex_* = 0 and stall = 0.
- Plain capture:
  - Stimulus: instr 0x8C22FFFC (lw, rs=1, rt=2, imm=-4), id_sign_ext=1, rf_rd1=0x100.
  - Next cycle: ex_imm = 0xFFFFFFFC, ex_rs_data = 0x100, ex_mem_read = 1.
- WB bypass:
  - Stimulus: wb_we=1, wb_rd=3, wb_data=0xDEAD; instruction rs=3 with rf_rd1=0x1. Repeat with wb_rd=0.
  - Expected: ex_rs_data = 0xDEAD; with wb_rd=0, ex_rs_data = 0x1.
- Load-use:
  - Stimulus: lw to r5 in EX, next instruction uses rt=5.
  - Expected: stall = 1 for exactly one cycle, one bubble (ex_valid=0, ex_ctrl=0), then the dependent instruction enters EX.
- Hold with refresh:
  - Stimulus: ex_hold=1 for 3 cycles; WB writes ex_rt's register with 0x55 in cycle 2.
  - Expected: stall = 1 for 3 cycles, all other ex_* constant, ex_rt_data = 0x55 from cycle 3.
- Flush priority:
  - Stimulus: flush=1 together with hz=1 and ex_hold=1.
  - Expected: stall = 0; next cycle ex_valid = 0 and ex_ctrl = 0.
